frame_buf_write_addr: RTL
=========================

FRAME_BUF_WRITE_ADDR -- requirements
Module: frame_buf_write_addr

Interface
REQ-001 Parameter ADDR_W, default 20: width of buffer write address.
REQ-002 Parameter H_ACTIVE, default 640: pixels per line.
REQ-003 Parameter V_ACTIVE, default 480: lines per frame.
REQ-004 Parameter X_W, default 10: column counter width; SHALL satisfy 2^X_W >= H_ACTIVE.
REQ-005 Parameter Y_W, default 9: line counter width; SHALL satisfy 2^Y_W >= V_ACTIVE.
REQ-006 clock  input  1  clock; all state updates on rising edge only.
REQ-007 reset  input  1  reset, synchronous, active-high.
REQ-008 we  input  1  pixel write enable; one pixel written per cycle when high.
REQ-009 sof  input  1  start-of-frame strobe, one cycle.
REQ-010 addr  output  ADDR_W  address of the pixel written this cycle (registered).
REQ-011 x  output  X_W  current column, 0..H_ACTIVE-1.
REQ-012 y  output  Y_W  current line, 0..V_ACTIVE-1.
REQ-013 line_end  output  1  one-cycle pulse after the last pixel of a line is written.
REQ-014 frame_end  output  1  one-cycle pulse after the last pixel of a frame is written.
REQ-015 buf_sel  output  1  buffer being written (0/1).
REQ-016 sync_err  output  1  sticky error flag.

Function
REQ-017 Two states, WAIT_SOF and ACTIVE; the block SHALL leave reset in WAIT_SOF.
REQ-018 In WAIT_SOF, we SHALL be ignored (no address advance) unless sof is high in the same cycle.
REQ-019 sof in any state SHALL set x=0, y=0, enter ACTIVE; if we is also high that cycle, the pixel SHALL be written at offset 0 and the counters SHALL advance to x=1.
REQ-020 addr SHALL equal base + y*H_ACTIVE + x, maintained by an incrementing linear counter (no multiplier); base = 0 for buf_sel=0, H_ACTIVE*V_ACTIVE for buf_sel=1.
REQ-021 In ACTIVE with we=1: x increments; at x=H_ACTIVE-1, x wraps to 0, y increments, line_end pulses next cycle.
REQ-022 At x=H_ACTIVE-1, y=V_ACTIVE-1 with we=1: x, y wrap to 0; line_end and frame_end pulse together next cycle; state returns to WAIT_SOF.
REQ-023 we=0 SHALL hold all counters and addr.
REQ-024 sof received in ACTIVE while (x,y) != (0,0) SHALL set sync_err=1 (truncated frame); sync_err clears only on reset.
REQ-025 sof in the same cycle as the last-pixel write SHALL take precedence: counters restart at 0 with no sync_err, frame_end still pulses.
REQ-026 Address arithmetic SHALL be unsigned, ADDR_W bits; parameters SHALL satisfy 2*H_ACTIVE*V_ACTIVE <= 2^ADDR_W (elaboration-time check).

Reset
REQ-027 reset SHALL have priority over sof and we.
REQ-028 Reset values: addr=0, x=0, y=0, line_end=0, frame_end=0, buf_sel=0, sync_err=0, state=WAIT_SOF.
REQ-029 Reset asserted mid-frame SHALL abandon the frame without a frame_end pulse.

Configuration
REQ-030 Macro FBW_DOUBLE_BUF_EN defined: buf_sel SHALL toggle on each completed frame (cycle of frame_end), ping-pong between the two buffer halves.
REQ-031 Macro FBW_DOUBLE_BUF_EN undefined: buf_sel SHALL be constant 0, base SHALL be 0, all frames written to the single buffer.

Verification (H_ACTIVE=4, V_ACTIVE=2, ADDR_W=5)
REQ-032 Reset, then we=1 for 5 cycles without sof -> addr stays 0, x=0, y=0.
REQ-033 sof+we, then we=1 for 7 cycles -> addr 0..7, line_end after addr 3, line_end+frame_end after addr 7, state WAIT_SOF.
REQ-034 Two full frames with FBW_DOUBLE_BUF_EN -> frame 2 addr 8..15, buf_sel 0->1->0; without macro -> frame 2 addr 0..7, buf_sel 0.
REQ-035 sof at x=2, y=0 -> sync_err=1, next pixel at addr 0 (base unchanged), sync_err held until reset.
REQ-036 we toggling 1,0,1,0 after sof -> addr advances only on we=1 cycles: 0,1,1,2.
REQ-037 Reset asserted at y=1, x=1 -> next cycle all outputs at reset values, no frame_end.

Source files
------------

// File: rtl/frame_buf_write_addr_if.sv
// Pixel write bus between a pixel source and the frame buffer write address generator.
// The source drives we/sof; the address generator returns the position, flags and buffer select.
interface frame_buf_write_addr_if #(
    parameter int ADDR_W = 20,
    parameter int X_W    = 10,
    parameter int Y_W    = 9
);
    logic              we;
    logic              sof;
    logic [ADDR_W-1:0] addr;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic              line_end;
    logic              frame_end;
    logic              buf_sel;
    logic              sync_err;

    modport master (
        output we, sof,
        input  addr, x, y, line_end, frame_end, buf_sel, sync_err
    );

    modport slave (
        input  we, sof,
        output addr, x, y, line_end, frame_end, buf_sel, sync_err
    );
endinterface

// File: rtl/frame_buf_write_addr.sv
// Frame buffer write address generator: linear address counter tracking (x, y) of incoming pixels.
// Define FBW_DOUBLE_BUF_EN to ping-pong frames between two buffer halves; undefined = single buffer.
module frame_buf_write_addr #(
    parameter int ADDR_W   = 20,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int X_W      = 10,
    parameter int Y_W      = 9
) (
    input  logic                   clock,
    input  logic                   reset,
    frame_buf_write_addr_if.slave  bus
);

    localparam logic [X_W-1:0]    X_LAST     = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0]    Y_LAST     = Y_W'(V_ACTIVE - 1);
    localparam logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(H_ACTIVE * V_ACTIVE);

    if (2 * H_ACTIVE * V_ACTIVE > 2 ** ADDR_W) begin : g_addr_w_check
        $error("ADDR_W too narrow for two frames of H_ACTIVE x V_ACTIVE");
    end
    if (2 ** X_W < H_ACTIVE) begin : g_x_w_check
        $error("X_W too narrow for H_ACTIVE");
    end
    if (2 ** Y_W < V_ACTIVE) begin : g_y_w_check
        $error("Y_W too narrow for V_ACTIVE");
    end

    typedef enum logic {
        WAIT_SOF,
        ACTIVE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [X_W-1:0]    x_next;
    logic [Y_W-1:0]    y_next;
    logic [ADDR_W-1:0] addr_next;
    logic              line_end_next;
    logic              frame_end_next;
    logic              buf_sel_next;
    logic              sync_err_next;

    // Position the current pixel is written at, after any sof restart is applied.
    logic [X_W-1:0]    cur_x;
    logic [Y_W-1:0]    cur_y;
    logic [ADDR_W-1:0] cur_addr;
    logic              writing;
    logic              last_pixel;

    function automatic logic [ADDR_W-1:0] base_of(input logic sel);
        return sel ? FRAME_SIZE : '0;
    endfunction

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_next     = state;
        x_next         = bus.x;
        y_next         = bus.y;
        addr_next      = bus.addr;
        line_end_next  = 1'b0;
        frame_end_next = 1'b0;
        buf_sel_next   = bus.buf_sel;
        sync_err_next  = bus.sync_err;
        cur_x          = bus.x;
        cur_y          = bus.y;
        cur_addr       = bus.addr;
        writing        = (state == ACTIVE) && bus.we;
        last_pixel     = writing && (bus.x == X_LAST) && (bus.y == Y_LAST);

        // sof coinciding with the last pixel lets that frame complete normally and just keeps us ACTIVE.
        if (bus.sof && !last_pixel) begin
            if ((state == ACTIVE) && ((bus.x != '0) || (bus.y != '0))) begin
                sync_err_next = 1'b1;
            end
            cur_x      = '0;
            cur_y      = '0;
            cur_addr   = base_of(bus.buf_sel);
            writing    = bus.we;
            state_next = ACTIVE;
            x_next     = '0;
            y_next     = '0;
            addr_next  = cur_addr;
        end

        if (writing) begin
            if (cur_x == X_LAST) begin
                x_next        = '0;
                line_end_next = 1'b1;
                if (cur_y == Y_LAST) begin
                    y_next         = '0;
                    frame_end_next = 1'b1;
`ifdef FBW_DOUBLE_BUF_EN
                    buf_sel_next   = ~bus.buf_sel;
`endif
                    addr_next      = base_of(buf_sel_next);
                    state_next     = bus.sof ? ACTIVE : WAIT_SOF;
                end else begin
                    y_next    = cur_y + Y_W'(1);
                    addr_next = cur_addr + ADDR_W'(1);
                end
            end else begin
                x_next    = cur_x + X_W'(1);
                addr_next = cur_addr + ADDR_W'(1);
            end
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= WAIT_SOF;
            bus.addr      <= '0;
            bus.x         <= '0;
            bus.y         <= '0;
            bus.line_end  <= 1'b0;
            bus.frame_end <= 1'b0;
            bus.buf_sel   <= 1'b0;
            bus.sync_err  <= 1'b0;
        end else begin
            state         <= state_next;
            bus.addr      <= addr_next;
            bus.x         <= x_next;
            bus.y         <= y_next;
            bus.line_end  <= line_end_next;
            bus.frame_end <= frame_end_next;
            bus.buf_sel   <= buf_sel_next;
            bus.sync_err  <= sync_err_next;
        end
    end

endmodule
